// File: rtl/osc_pkg.sv
// Shared types and constants for the note oscillator slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package osc_pkg;

    // Default width of the full-period count and smallest audible period.
    localparam int W       = 16;
    localparam int MIN_DIV = 2;

    // Offset-binary midscale: the sample value whenever no note is sounding.
    localparam logic [7:0] SAMPLE_MID = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } osc_state_t;

endpackage

// File: rtl/osc_period_counter.sv
// Period counter: latches the period length, counts cycles and flags the phase split and period end.
// Latency: load/clear/increment take effect at the next clk edge; the hit flags are combinational from the registers.
// Backpressure: none; the owning FSM decides every cycle whether to load, clear or count.
//
// Ports:
//   clk, nrst       clock and asynchronous active-low reset
//   load            latch div_in into div_lat and restart the count at 0
//   clr             restart the count at 0, keeping div_lat
//   inc             advance the count by one
//   div_in          full-period count to latch on load
//   half_hit        count is on the last cycle of the high phase
//   end_hit         count is on the last cycle of the whole period
module osc_period_counter #(
    parameter int W = osc_pkg::W
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] div_in,
    output logic         half_hit,
    output logic         end_hit
);

    logic [W-1:0] count;
    logic [W-1:0] div_lat;
    logic [W-1:0] half;

    // High phase gets the floor of half the period, so odd periods spend
    // the extra cycle in the low phase.
    assign half     = div_lat >> 1;
    assign half_hit = (count == half - W'(1));
    assign end_hit  = (count == div_lat - W'(1));

    // The count runs 0..div_lat-1 and is reloaded at every boundary, so it
    // never wraps.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count   <= '0;
            div_lat <= '0;
        end else if (load) begin
            div_lat <= div_in;
            count   <= '0;
        end else if (clr) begin
            count   <= '0;
        end else if (inc) begin
            count   <= count + W'(1);
        end
    end

endmodule

// File: rtl/note_oscillator.sv
// Note oscillator: turns a full-period count into a glitch-free square wave and offset-binary sample.
// Latency: 1 cycle from note_on with a legal div_in to the first high cycle and period_tick.
// Backpressure: none; div_in and note_on are sampled only at period boundaries (or while idle).
//
// Ports:
//   clk, nrst       10 MHz clock and asynchronous active-low reset
//   note_on         key held (level)
//   div_in          full-period count for the selected note/octave
//   wave_out        1 during the high phase
//   sample_out      midscale+AMP high, midscale-AMP low, midscale idle
//   period_tick     one-cycle pulse in the first cycle of every period
//   active          1 whenever a period is in progress
module note_oscillator #(
    parameter int         W       = osc_pkg::W,
    parameter int         MIN_DIV = osc_pkg::MIN_DIV,
    parameter logic [7:0] AMP     = 8'd96
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         note_on,
    input  logic [W-1:0] div_in,
    output logic         wave_out,
    output logic [7:0]   sample_out,
    output logic         period_tick,
    output logic         active
);

    import osc_pkg::*;

    localparam logic [7:0] SAMPLE_HI = SAMPLE_MID + AMP;
    localparam logic [7:0] SAMPLE_LO = SAMPLE_MID - AMP;

    osc_state_t state;
    osc_state_t state_nxt;
    logic       start_ok;
    logic       load;
    logic       clr;
    logic       inc;
    logic       half_hit;
    logic       end_hit;

    // Periods shorter than MIN_DIV cannot be split into two phases; treat them as silence.
    assign start_ok = note_on && (div_in >= W'(MIN_DIV));

    osc_period_counter #(
        .W (W)
    ) u_cnt (
        .clk      (clk),
        .nrst     (nrst),
        .load     (load),
        .clr      (clr),
        .inc      (inc),
        .div_in   (div_in),
        .half_hit (half_hit),
        .end_hit  (end_hit)
    );

    // Inputs are only looked at while idle or on the last cycle of a period,
    // which is what keeps pitch/key changes free of runt pulses.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clr       = 1'b0;
        inc       = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = HIGH;
                    load      = 1'b1;
                end
            end
            HIGH: begin
                inc = 1'b1;
                if (half_hit) begin
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (end_hit) begin
                    if (start_ok) begin
                        state_nxt = HIGH;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        clr       = 1'b1;
                    end
                end else begin
                    inc = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                clr       = 1'b1;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // register; every load marks the first cycle of a new period.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            wave_out    <= 1'b0;
            sample_out  <= SAMPLE_MID;
            period_tick <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_nxt;
            wave_out    <= (state_nxt == HIGH);
            period_tick <= load;
            active      <= (state_nxt != IDLE);
            case (state_nxt)
                HIGH:    sample_out <= SAMPLE_HI;
                LOW:     sample_out <= SAMPLE_LO;
                default: sample_out <= SAMPLE_MID;
            endcase
        end
    end

endmodule

// File: tb/tb_note_oscillator.sv
// Bench for note_oscillator: directed per-cycle vectors feed a scoreboard queue checked by a monitor.
// Latency: expected values are queued for the cycle after the edge that samples each input vector.
// Backpressure: n/a.
module tb_note_oscillator;

    localparam int W = 16;

    typedef struct packed {
        logic       wave;
        logic [7:0] sample;
        logic       tick;
        logic       act;
    } obs_t;

    logic         clk;
    logic         nrst;
    logic         note_on;
    logic [W-1:0] div_in;
    logic         wave_out;
    logic [7:0]   sample_out;
    logic         period_tick;
    logic         active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    obs_t  exp_q[$];
    string lbl_q[$];

    note_oscillator #(
        .W       (W),
        .MIN_DIV (2),
        .AMP     (8'd96)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .note_on     (note_on),
        .div_in      (div_in),
        .wave_out    (wave_out),
        .sample_out  (sample_out),
        .period_tick (period_tick),
        .active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written cycle codes: T = first high cycle (tick), H = high, L = low, I = idle.
    function automatic obs_t code2obs(input byte c);
        obs_t o;
        case (c)
            "T":     o = '{wave: 1'b1, sample: 8'hE0, tick: 1'b1, act: 1'b1};
            "H":     o = '{wave: 1'b1, sample: 8'hE0, tick: 1'b0, act: 1'b1};
            "L":     o = '{wave: 1'b0, sample: 8'h20, tick: 1'b0, act: 1'b1};
            default: o = '{wave: 1'b0, sample: 8'h80, tick: 1'b0, act: 1'b0};
        endcase
        return o;
    endfunction

    task automatic check_now(input string name, input obs_t e);
        checks++;
        if (wave_out !== e.wave || sample_out !== e.sample ||
            period_tick !== e.tick || active !== e.act) begin
            errors++;
            $display("FAIL %s t=%0t: got wave=%b sample=%h tick=%b active=%b, expected wave=%b sample=%h tick=%b active=%b",
                     name, $time, wave_out, sample_out, period_tick, active,
                     e.wave, e.sample, e.tick, e.act);
        end
    endtask

    // Monitor: outputs are produced every cycle, so every cycle with a pending
    // expectation is compared, one clean time unit after the active edge.
    initial begin
        obs_t  e;
        string l;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                l = lbl_q.pop_front();
                check_now(l, e);
            end
        end
    end

    // Entered at a negedge: drive one input vector, queue what the next edge must produce.
    task automatic step(input logic n, input logic [W-1:0] d, input byte c, input string name);
        note_on = n;
        div_in  = d;
        exp_q.push_back(code2obs(c));
        lbl_q.push_back(name);
        @(negedge clk);
    endtask

    task automatic run(input logic n, input logic [W-1:0] d, input string codes, input string name);
        for (int i = 0; i < codes.len(); i++) begin
            step(n, d, codes[i], name);
        end
    endtask

    task automatic run_n(input logic n, input logic [W-1:0] d, input byte c, input int cnt, input string name);
        for (int i = 0; i < cnt; i++) begin
            step(n, d, c, name);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        nrst    = 1'b1;
        note_on = 1'b0;
        div_in  = '0;
        #1 nrst = 1'b0;
        #1 check_now("reset_state", code2obs("I"));
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        run(1'b0, 16'd0, "III", "idle_after_reset");

        // div=4: 2 high / 2 low, ticks every 4 cycles, ending with note_off at the boundary.
        run(1'b1, 16'd4, "THLLTHLLTHLL", "div4");
        run(1'b0, 16'd4, "III", "div4_stop");

        // div=5: odd period, extra cycle goes to the low phase.
        run(1'b1, 16'd5, "THLLLTHLLL", "div5");
        run(1'b0, 16'd5, "II", "div5_stop");

        // div changed 4->8 during the 2nd high cycle: current period stays 4.
        run(1'b1, 16'd4, "TH", "div_change_a");
        run(1'b1, 16'd8, "LLTHHHLLLL", "div_change_b");
        run(1'b0, 16'd8, "II", "div_change_stop");

        // note_on dropped in the 1st high cycle of div=6: period completes, then idle.
        run(1'b1, 16'd6, "T", "noteoff_a");
        run(1'b0, 16'd6, "HHLLLIIII", "noteoff_b");

        // note_on dropped then re-asserted before the boundary: no gap.
        run(1'b1, 16'd6, "T", "reassert_a");
        run(1'b0, 16'd6, "HHL", "reassert_b");
        run(1'b1, 16'd6, "LLTHH", "reassert_c");
        run(1'b0, 16'd6, "LLLI", "reassert_d");

        // Illegal periods are silence; div=2 starts the very next cycle.
        run(1'b1, 16'd1, "IIIIII", "div1_silent");
        run(1'b1, 16'd0, "IIII", "div0_silent");
        run(1'b1, 16'd2, "TLTLTL", "div2");
        run(1'b0, 16'd2, "II", "div2_stop");

        // Middle C: 19111 high, 19112 low, next tick 38223 cycles after the first.
        run(1'b1, 16'd38223, "T", "c4_start");
        run_n(1'b1, 16'd38223, "H", 19110, "c4_high");
        run_n(1'b1, 16'd38223, "L", 19112, "c4_low");
        run(1'b1, 16'd38223, "T", "c4_tick2");
        #2 nrst = 1'b0;
        #1 check_now("c4_async_reset", code2obs("I"));
        @(negedge clk);
        nrst = 1'b1;
        run(1'b0, 16'd0, "II", "c4_after_reset");

        // Reset mid-LOW of div=10: outputs drop immediately, restart needs a fresh edge.
        run(1'b1, 16'd10, "THHHHLL", "rst_mid_a");
        #2 nrst = 1'b0;
        #1 check_now("rst_mid_async", code2obs("I"));
        @(negedge clk);
        check_now("rst_mid_held", code2obs("I"));
        @(negedge clk);
        nrst = 1'b1;
        run(1'b1, 16'd10, "THHHH", "rst_mid_restart");
        run(1'b0, 16'd10, "LLLLLI", "rst_mid_stop");

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
